// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the 110 sequence detector.
// Accepts WIDTH-bit words via valid/ready and emits one bit per clock.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic             w_shifting;
    logic             w_last;
    logic             w_accept;
    logic             w_head;

    assign w_shifting = (r_state == SHIFT);
    assign w_last     = w_shifting && (r_count == '0);
    assign load_ready = (r_state == IDLE) || w_last;
    assign w_accept   = load_valid && load_ready;
    assign w_head     = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

    assign ser_out    = w_shifting ? w_head : 1'b0;
    assign ser_valid  = w_shifting;
    assign ser_last   = w_last;
    assign busy       = w_shifting;

    // State register; reset aborts any word in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: stay in SHIFT across back-to-back words
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last && !w_accept) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Shift register: load on accept, zero-fill shift while shifting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
        end else if (w_accept) begin
            r_shift <= load_data;
        end else if (w_shifting) begin
            if (MSB_FIRST) begin
                r_shift <= r_shift << 1;
            end else begin
                r_shift <= r_shift >> 1;
            end
        end
    end

    // Bit counter: reload on accept, count down and hold at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= CW'(WIDTH - 1);
        end else if (w_shifting && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule
